// File: rtl/uart_pkg.sv
// Shared UART constants: receiver FSM states, parity-mode codes and oversampling points.
package uart_pkg;

  localparam int unsigned OSR = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BREAK_WAIT
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Majority window is samples 7..9; a bit period ends after sample OSR-1.
  localparam logic [3:0] SAMPLE_A    = 4'd7;
  localparam logic [3:0] SAMPLE_B    = 4'd8;
  localparam logic [3:0] SAMPLE_C    = 4'd9;
  localparam logic [3:0] SAMPLE_LAST = 4'(OSR - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: down-counter reloading i_div-1 (0 behaves as 1), with a
// synchronous reload used to phase-align ticks to a detected start edge.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic                 i_reload,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] cnt_reg;
  logic [DIV_WIDTH-1:0] reload_val;

  assign reload_val = (i_div == '0) ? '0 : i_div - 1'b1;
  assign o_tick     = (cnt_reg == '0) && !i_reload;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg <= '0;
    end else if (i_reload || (cnt_reg == '0)) begin
      cnt_reg <= reload_val;
    end else begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with majority vote, runtime parity/stop modes and a
// valid/ready output with sticky overrun. Break detection is enabled by UART_RX_BREAK_DETECT_EN.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx_serial,
  input  logic [DIV_WIDTH-1:0]  i_baud_div,
  input  logic [1:0]            i_parity_mode,
  input  logic                  i_two_stop,
  input  logic                  i_rx_ready,
  input  logic                  i_err_clr,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_rx_perr,
  output logic                  o_rx_ferr,
  output logic                  o_overrun,
  output logic                  o_break
);

`ifdef UART_RX_BREAK_DETECT_EN
  localparam bit BREAK_EN = 1'b1;
`else
  localparam bit BREAK_EN = 1'b0;
`endif

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  rx_state_t             state_reg;
  logic [1:0]            sync_reg;
  logic                  rx_prev_reg;
  logic [3:0]            samp_cnt_reg;
  logic [3:0]            bit_cnt_reg;
  logic [3:0]            hi_cnt_reg;
  logic [1:0]            vote_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  perr_reg;
  logic                  ferr_reg;
  logic                  zero_reg;
  logic [1:0]            par_mode_reg;
  logic                  two_stop_reg;
  logic                  commit_reg;
  logic                  brk_pend_reg;
  logic                  break_reg;

  logic rx_sync, start_edge, tick, bit_maj, frame_zero, par_en, par_exp;

  assign rx_sync    = sync_reg[1];
  assign start_edge = (state_reg == ST_IDLE) && rx_prev_reg && !rx_sync;
  assign bit_maj    = maj3(vote_reg[0], vote_reg[1], rx_sync);
  assign frame_zero = zero_reg & ~bit_maj;
  assign par_en     = (par_mode_reg == PAR_EVEN) || (par_mode_reg == PAR_ODD);
  assign par_exp    = (^data_reg) ^ (par_mode_reg == PAR_ODD);
  assign o_break    = BREAK_EN ? break_reg : 1'b0;

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_div    (i_baud_div),
    .i_reload (start_edge),
    .o_tick   (tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], i_rx_serial};
      rx_prev_reg <= rx_sync;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      samp_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      hi_cnt_reg   <= '0;
      vote_reg     <= 2'b11;
      data_reg     <= '0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      zero_reg     <= 1'b0;
      par_mode_reg <= PAR_NONE;
      two_stop_reg <= 1'b0;
      commit_reg   <= 1'b0;
      brk_pend_reg <= 1'b0;
    end else begin
      commit_reg   <= 1'b0;
      brk_pend_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_edge) begin
            state_reg    <= ST_START;
            samp_cnt_reg <= '0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            zero_reg     <= 1'b1;
            par_mode_reg <= i_parity_mode;
            two_stop_reg <= i_two_stop;
          end
        end
        ST_BREAK_WAIT: begin
          // Re-arm only after a full bit time of continuous idle line.
          if (tick) begin
            if (!rx_sync) begin
              hi_cnt_reg <= '0;
            end else if (hi_cnt_reg == SAMPLE_LAST) begin
              hi_cnt_reg <= '0;
              state_reg  <= ST_IDLE;
            end else begin
              hi_cnt_reg <= hi_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          if (tick) begin
            samp_cnt_reg <= samp_cnt_reg + 1'b1;
            if (samp_cnt_reg == SAMPLE_A) vote_reg[0] <= rx_sync;
            if (samp_cnt_reg == SAMPLE_B) vote_reg[1] <= rx_sync;
            if (samp_cnt_reg == SAMPLE_C) begin
              case (state_reg)
                ST_START: if (bit_maj) state_reg <= ST_IDLE;
                ST_DATA: begin
                  data_reg <= {bit_maj, data_reg[DATA_WIDTH-1:1]};
                  zero_reg <= frame_zero;
                end
                ST_PARITY: begin
                  perr_reg <= (bit_maj != par_exp);
                  zero_reg <= frame_zero;
                end
                default: begin
                  ferr_reg <= ferr_reg | ~bit_maj;
                  zero_reg <= frame_zero;
                  // Last stop decided mid-bit: leave half a bit of margin to resync.
                  if ((state_reg == ST_STOP2) || !two_stop_reg) begin
                    if (BREAK_EN && frame_zero) begin
                      brk_pend_reg <= 1'b1;
                      hi_cnt_reg   <= '0;
                      state_reg    <= ST_BREAK_WAIT;
                    end else begin
                      commit_reg <= 1'b1;
                      state_reg  <= ST_IDLE;
                    end
                  end
                end
              endcase
            end
            if (samp_cnt_reg == SAMPLE_LAST) begin
              case (state_reg)
                ST_START: begin
                  state_reg   <= ST_DATA;
                  bit_cnt_reg <= '0;
                end
                ST_DATA: begin
                  if (bit_cnt_reg == LAST_BIT) state_reg <= par_en ? ST_PARITY : ST_STOP1;
                  else                         bit_cnt_reg <= bit_cnt_reg + 1'b1;
                end
                ST_PARITY: state_reg <= ST_STOP1;
                ST_STOP1:  state_reg <= ST_STOP2;
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_rx_perr  <= 1'b0;
      o_rx_ferr  <= 1'b0;
      o_overrun  <= 1'b0;
      break_reg  <= 1'b0;
    end else begin
      break_reg <= brk_pend_reg;
      if (commit_reg && (!o_rx_valid || i_rx_ready)) begin
        o_rx_data  <= data_reg;
        o_rx_perr  <= perr_reg;
        o_rx_ferr  <= ferr_reg;
        o_rx_valid <= 1'b1;
      end else if (o_rx_valid && i_rx_ready) begin
        o_rx_valid <= 1'b0;
      end
      if (commit_reg && o_rx_valid && !i_rx_ready) o_overrun <= 1'b1;
      else if (i_err_clr)                          o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: driver pushes expected words, a negedge monitor pops on handshake.
module tb_uart_rx_os;

`ifdef UART_RX_BREAK_DETECT_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] div = 16'd27;
  logic [1:0]  pmode = 2'b00;
  logic        two_stop = 1'b0;
  logic        ready = 1'b1;
  logic        err_clr = 1'b0;
  logic [7:0]  rdata;
  logic        rvalid, rperr, rferr, ovr, brk;

  always #10 clk = ~clk;

  uart_rx_os #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rx_serial   (rx),
    .i_baud_div    (div),
    .i_parity_mode (pmode),
    .i_two_stop    (two_stop),
    .i_rx_ready    (ready),
    .i_err_clr     (err_clr),
    .o_rx_data     (rdata),
    .o_rx_valid    (rvalid),
    .o_rx_perr     (rperr),
    .o_rx_ferr     (rferr),
    .o_overrun     (ovr),
    .o_break       (brk)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   brk_seen = 0;
  bit   valid_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int bit_clks();
    return ((div == 16'd0) ? 1 : int'(div)) * 16;
  endfunction

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      rx = v[i];
      repeat (bit_clks()) wait_clk();
    end
  endtask

  // Reference: expected parity bit is the XOR of data (inverted for odd mode).
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1,
                            input logic s2, input bit push, input int gap);
    logic [15:0] v;
    int          n;
    bit          pen, pe, fe, is_brk;
    logic        exp_p;
    pen    = (pmode == 2'b01) || (pmode == 2'b10);
    exp_p  = (^d) ^ (pmode == 2'b10);
    pe     = pen && (pbit != exp_p);
    fe     = !s1 || (two_stop && !s2);
    is_brk = (d == 8'h00) && (!pen || !pbit) && !s1 && (!two_stop || !s2);
    v = '0;
    v[8:1] = d;
    n = 9;
    if (pen) begin v[n] = pbit; n++; end
    v[n] = s1; n++;
    if (two_stop) begin v[n] = s2; n++; end
    if (push && !(BRK && is_brk)) sb.push_back({d, pe, fe});
    send_bits(v, n);
    rx = 1'b1;
    repeat (gap * bit_clks()) wait_clk();
    $display("frame data=%02h par_mode=%0d pbit=%0b stops=%0b%0b div=%0d exp_perr=%0b exp_ferr=%0b",
             d, pmode, pbit, s1, s2, div, pe, fe);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      wait_clk();
    end
    check("scoreboard_drain", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, rdata, 0);
    check({tag, "_valid"}, rvalid, 0);
    check({tag, "_perr"}, rperr, 0);
    check({tag, "_ferr"}, rferr, 0);
    check({tag, "_overrun"}, ovr, 0);
    check({tag, "_break"}, brk, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rvalid) valid_seen = 1'b1;
        if (brk) brk_seen++;
        if (rvalid && ready) begin
          if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_word: got data=%02h perr=%0b ferr=%0b expected none", rdata, rperr, rferr);
          end else begin
            e = sb.pop_front();
            $display("accept data=%02h perr=%0b ferr=%0b (exp %02h %0b %0b)", rdata, rperr, rferr, e.d, e.pe, e.fe);
            check("word_data", rdata, e.d);
            check("word_perr", rperr, e.pe);
            check("word_ferr", rferr, e.fe);
          end
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int brk0;
    int bc;
    logic [7:0] d;
    logic [15:0] v;
    repeat (5) wait_clk();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) wait_clk();
    check("post_reset_valid", rvalid, 0);

    // 8N1 back-to-back words
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    wait_drain(200);

    pmode = 2'b01;
    send_frame(8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    pmode = 2'b10;
    send_frame(8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    pmode = 2'b00;
    wait_drain(200);

    // Overrun: second word dropped while first is held
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    check("overrun_set", ovr, 1);
    check("held_valid", rvalid, 1);
    check("held_data", rdata, 8'h11);
    err_clr = 1'b1;
    wait_clk();
    err_clr = 1'b0;
    check("overrun_cleared", ovr, 0);
    ready = 1'b1;
    wait_clk();
    check("valid_drop_after_accept", rvalid, 0);
    wait_drain(50);

    // Short low glitch must be rejected as a false start
    valid_seen = 1'b0;
    rx = 1'b0;
    repeat (4 * int'(div)) wait_clk();
    rx = 1'b1;
    repeat (3 * bit_clks()) wait_clk();
    check("glitch_no_valid", valid_seen, 0);

    two_stop = 1'b1;
    send_frame(8'h5E, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    two_stop = 1'b0;
    wait_drain(200);

    // Line held low for 12 bit times
    brk0 = brk_seen;
    if (!BRK) sb.push_back({8'h00, 1'b0, 1'b1});
    rx = 1'b0;
    repeat (12 * bit_clks()) wait_clk();
    rx = 1'b1;
    repeat (3 * bit_clks()) wait_clk();
    $display("break frame: break pulses=%0d", brk_seen - brk0);
    check("break_pulses", brk_seen - brk0, BRK ? 1 : 0);
    wait_drain(200);

    // Reset in the middle of a frame clears a held word and all flags
    ready = 1'b0;
    send_frame(8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    check("pre_reset_held_valid", rvalid, 1);
    check("pre_reset_held_data", rdata, 8'h96);
    bc = bit_clks();
    d = 8'h5A;
    v = {7'b0, d, 1'b0};
    send_bits(v, 4);
    rx = d[3];
    repeat (bc / 2) wait_clk();
    #3 rst_n = 1'b0;
    #1 check_all_zero("midframe_reset");
    repeat (5) wait_clk();
    rx = 1'b1;
    repeat (3) wait_clk();
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (bc) wait_clk();
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    wait_drain(200);

    // Randomized frames across divisors, parity and stop modes
    for (int k = 0; k < 8; k++) begin
      div      = 16'($urandom_range(0, 6));
      pmode    = 2'($urandom_range(0, 3));
      two_stop = 1'($urandom_range(0, 1));
      d        = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      send_frame(d, 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 1'b1, 2);
    end
    wait_drain(200);
    if (!BRK) check("no_break_when_disabled", brk_seen, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
